key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Eight independent key conditioners: 2-flop synchronizer, polarity normalization,
// debounce FSM per key and optional auto-repeat while held.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock_i,
  input  logic       rst_ni,
  input  logic [7:0] key_in_i,
  input  logic [7:0] repeat_en_i,
  output logic [7:0] key_level_o,
  output logic [7:0] key_pulse_o
);

  // state      | meaning
  // IDLE       | released, waiting for a pressed sample
  // DB_PRESS   | counting consecutive pressed samples
  // HELD       | accepted press, repeat timer running when enabled
  // DB_RELEASE | counting consecutive released samples
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_e;

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_LIM = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_LIM = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [7:0]    UNPRESSED_RAW = KEY_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam bit            DB_SINGLE = (DEBOUNCE_CYCLES <= 1);

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] sample;

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= UNPRESSED_RAW;
      sync2_q <= UNPRESSED_RAW;
    end else begin
      sync1_q <= key_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar k = 0; k < 8; k++) begin : g_key
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rep_phase_q, rep_phase_d;
    logic          rep_fire;
    logic          level_q, level_d, pulse_q, pulse_d;

    // Saturating increment keeps a stuck counter from ever wrapping into a match.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

    always_ff @(posedge clock_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        rep_phase_q <= 1'b0;
        level_q     <= 1'b0;
        pulse_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        rep_phase_q <= rep_phase_d;
        level_q     <= level_d;
        pulse_q     <= pulse_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      case (state_q)
        IDLE: begin
          if (sample[k]) begin
            state_d     = DB_SINGLE ? HELD : DB_PRESS;
            cnt_d       = DB_SINGLE ? '0 : ONE;
            rep_phase_d = 1'b0;
          end
        end
        DB_PRESS: begin
          if (!sample[k]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= DB_LIM) begin
            state_d     = HELD;
            cnt_d       = '0;
            rep_phase_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          rep_phase_d = 1'b0;
          if (!sample[k]) begin
            state_d = DB_SINGLE ? IDLE : DB_RELEASE;
            cnt_d   = DB_SINGLE ? '0 : ONE;
          end else if (!repeat_en_i[k]) begin
            cnt_d = '0;
          end else if (cnt_inc >= (rep_phase_q ? RP_LIM : RD_LIM)) begin
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            rep_fire    = 1'b1;
            cnt_d       = '0;
            rep_phase_d = 1'b1;
          end else begin
            cnt_d       = cnt_inc;
            rep_phase_d = rep_phase_q;
          end
        end
        DB_RELEASE: begin
          if (sample[k]) begin
            state_d     = HELD;
            cnt_d       = '0;
            rep_phase_d = 1'b0;
          end else if (cnt_inc >= DB_LIM) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      level_d = (state_d == HELD) || (state_d == DB_RELEASE);
      pulse_d = ((state_q == IDLE || state_q == DB_PRESS) && state_d == HELD) ||
                (state_q == HELD && state_d == HELD && rep_fire);
    end

    assign key_level_o[k] = level_q;
    assign key_pulse_o[k] = pulse_q;
  end

endmodule
